rr_arb_mux: RTL

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered, handshaked output stage. It generalises the fixed 2/4/8-way select muxes on the datapath. It is used wherever several producers share one bus: memory-port sharing, MAR/MDR source selection under contention, and the debug/IO merge. Selection is round-robin, fixed-priority or forced-select. Each accepted word is held in a one-entry output register until the consumer takes it.

---
 rtl/rr_arb_mux.sv | 95 +++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-way arbitrating mux with a one-entry registered output.
// Round-robin, fixed-priority or forced-select grant.
module rr_arb_mux #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [1:0]         mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gidx;
    logic [SELW-1:0] nptr;
    logic            gvld;
    logic            accept;
    logic            load;
    logic            rr_mode;
    logic [N-1:0]    grant;
    int              j;

    // Loops run from the far end so the lowest-ranked match wins.
    always_comb begin
        gidx = '0;
        gvld = 1'b0;
        j    = 0;
        case (mode)
            2'b01: begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (in_valid[k]) begin
                        gidx = SELW'(k);
                        gvld = 1'b1;
                    end
                end
            end
            2'b10: begin
                for (int k = 0; k < N; k++) begin
                    if (sel == SELW'(k) && in_valid[k]) begin
                        gidx = SELW'(k);
                        gvld = 1'b1;
                    end
                end
            end
            default: begin
                for (int k = N - 1; k >= 0; k--) begin
                    j = int'(ptr) + k;
                    if (j >= N) j = j - N;
                    if (in_valid[j]) begin
                        gidx = SELW'(j);
                        gvld = 1'b1;
                    end
                end
            end
        endcase
    end

    assign accept  = !out_valid || out_ready;
    assign load    = gvld && accept;
    assign rr_mode = (mode == 2'b00) || (mode == 2'b11);
    assign grant   = gvld ? ({{(N-1){1'b0}}, 1'b1} << gidx) : '0;
    assign in_ready = grant & {N{accept}};

    // Explicit wrap keeps ptr below N when N is not a power of two.
    assign nptr = (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            if (load) begin
                out_data  <= in_data[int'(gidx)*WIDTH +: WIDTH];
                out_src   <= gidx;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load && rr_mode) begin
                ptr <= nptr;
            end
        end
    end

endmodule
